core2axi_lite_ot: RTL and testbench
===================================

Name: core2axi_lite_ot

Overview:
- Next-generation core-side data bridge: converts the core data request/grant/rvalid protocol into single-beat AXI4-Lite master transactions.
- Unlike the current single-transaction bridge, it supports up to MAX_OUTSTANDING in-flight accesses with in-order response return.
- It also reports error responses and supports a strict read/write ordering mode.
- Sits between the core data port and the SoC AXI crossbar, in place of the current bridge and its wrapper.

Parameters:
- ADDR_WIDTH, 32, address width of core and AXI address ports.
- DATA_WIDTH, 32, data width; only 32 or 64 are legal; byte-enable/strobe width BE_W = DATA_WIDTH/8.
- MAX_OUTSTANDING, 4, maximum issued-but-unanswered transactions; power of 2, at least 1.
- STRICT_ORDER, 1, 1 = never mix reads and writes in flight; 0 = mixing allowed.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- data_req_i  in  1  core request
- data_gnt_o  out  1  grant, combinational
- data_rvalid_o  out  1  response valid, one-cycle pulse
- data_err_o  out  1  error on current response, valid only with rvalid
- data_addr_i  in  ADDR_WIDTH  request address
- data_we_i  in  1  1 = write
- data_be_i  in  BE_W  byte enables
- data_wdata_i  in  DATA_WIDTH  write data
- data_rdata_o  out  DATA_WIDTH  read data
- aw_addr_o  out  ADDR_WIDTH  write address
- aw_prot_o  out  3  constant 3'b000
- aw_valid_o  out  1  write address valid
- aw_ready_i  in  1  write address ready
- w_data_o  out  DATA_WIDTH  write data
- w_strb_o  out  BE_W  write strobes
- w_valid_o  out  1  write data valid
- w_ready_i  in  1  write data ready
- b_resp_i  in  2  write response
- b_valid_i  in  1  write response valid
- b_ready_o  out  1  write response ready
- ar_addr_o  out  ADDR_WIDTH  read address
- ar_prot_o  out  3  constant 3'b000
- ar_valid_o  out  1  read address valid
- ar_ready_i  in  1  read address ready
- r_data_i  in  DATA_WIDTH  read data
- r_resp_i  in  2  read response
- r_valid_i  in  1  read data valid
- r_ready_o  out  1  read data ready

Behaviour:
- Reset (async, rst_i=1): all valids 0, data_rvalid_o 0, data_err_o 0, data_rdata_o 0, address/data/strobe registers 0, outstanding count 0, order FIFO empty. As a consequence b_ready_o = r_ready_o = 0.
- Reset mid-operation abandons all in-flight transactions. Interconnect and slaves share rst_i.
- Stall conditions (any one true blocks grant):
  - any of aw_valid_o / w_valid_o / ar_valid_o still high;
  - count == MAX_OUTSTANDING (registered count; a same-cycle pop does not free a slot);
  - STRICT_ORDER=1 and count != 0 and data_we_i != type of the last-issued transaction.
- data_gnt_o = data_req_i && !stall.
- On grant cycle N, the request is captured and a type bit (we) is pushed into the order FIFO (depth MAX_OUTSTANDING).
- At N+1:
  - Write: aw_valid_o and w_valid_o both assert.
  - Read: ar_valid_o asserts.
- Each valid holds until its own handshake. AW and W drop independently, in any order or together.
- Channel payload registers stay stable while the corresponding valid is high.
- Response acceptance is gated by the order FIFO head:
  - r_ready_o = FIFO non-empty && head == read.
  - b_ready_o = FIFO non-empty && head == write.
  - An out-of-order B or R waits on the bus until it reaches the head.
- On an R or B handshake at cycle M, the FIFO pops. At M+1:
  - data_rvalid_o = 1 for exactly one cycle.
  - data_rdata_o = r_data_i for reads, 0 for writes.
  - data_err_o = resp[1] (SLVERR/DECERR).
- data_rdata_o holds its value between pulses.
- Outstanding count: +1 on grant, -1 on pop, unchanged when both occur in the same cycle.
- Best-case read latency: grant N, AR handshake N+1, R at N+2, data_rvalid_o at N+3.
- Back-to-back grants: minimum one request every 2 cycles (N, N+2) when ready inputs are held at 1.
- When STRICT_ORDER=1, a type switch waits until count reaches 0, so a read can never pass an earlier write.

Test Plan:
- Single read to 0x1000, ar_ready=1, r_valid the next cycle with data 0xDEADBEEF, resp=00 -> gnt at N, ar_valid N+1, data_rvalid_o N+3 with rdata 0xDEADBEEF, err 0.
- Write 0x2000, wdata 0x12345678, be 4'b0011; w_ready delayed 3 cycles after aw_ready -> aw_valid drops first, w_valid holds 3 more cycles with strb 0011; B resp=10 -> rvalid pulse with err=1, rdata=0.
- MAX_OUTSTANDING=4, 6 back-to-back reads, R delayed 20 cycles -> exactly 4 grants, gnt low until first R pop; responses returned in issue order.
- STRICT_ORDER=1: write then immediate read, both req held -> read gnt withheld until write rvalid pulse and count=0. STRICT_ORDER=0 -> read granted 2 cycles after the write.
- STRICT_ORDER=0: write then read outstanding, R arrives before B -> r_ready_o stays 0 until B handshake; core sees write response then read response.
- Assert rst_i with 3 transactions in flight -> all outputs 0 asynchronously; after release, new read completes normally with count starting at 0.

Source files
------------

// File: rtl/core2axi_lite_ot.sv
// ---------------------------------------------------------------------------
// core2axi_lite_ot
//
// Core data port (req/gnt/rvalid) to AXI4-Lite master bridge with up to
// MAX_OUTSTANDING single-beat transactions in flight.
//
// How it works:
// - Each granted request issues one AW+W or one AR beat.
// - A small FIFO records the issue order (write/read bit).
// - Only the response channel matching the FIFO head is made ready, so
//   responses always return to the core in issue order, even when the
//   interconnect offers them out of order.
// - With STRICT_ORDER set, reads and writes are never in flight together.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   data_req_i          core request
//   data_gnt_o          grant (combinational)
//   data_rvalid_o       one-cycle response pulse
//   data_err_o          error flag, meaningful only with data_rvalid_o
//   data_addr_i         request address
//   data_we_i           1 = write
//   data_be_i           byte enables
//   data_wdata_i        write data
//   data_rdata_o        read data (held between pulses, 0 after a write)
//   aw_* / w_* / b_*    AXI4-Lite write address, data and response channels
//   ar_* / r_*          AXI4-Lite read address and data channels
// ---------------------------------------------------------------------------
module core2axi_lite_ot #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STRICT_ORDER    = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      data_req_i,
    output logic                      data_gnt_o,
    output logic                      data_rvalid_o,
    output logic                      data_err_o,
    input  logic [ADDR_WIDTH-1:0]     data_addr_i,
    input  logic                      data_we_i,
    input  logic [DATA_WIDTH/8-1:0]   data_be_i,
    input  logic [DATA_WIDTH-1:0]     data_wdata_i,
    output logic [DATA_WIDTH-1:0]     data_rdata_o,
    output logic [ADDR_WIDTH-1:0]     aw_addr_o,
    output logic [2:0]                aw_prot_o,
    output logic                      aw_valid_o,
    input  logic                      aw_ready_i,
    output logic [DATA_WIDTH-1:0]     w_data_o,
    output logic [DATA_WIDTH/8-1:0]   w_strb_o,
    output logic                      w_valid_o,
    input  logic                      w_ready_i,
    input  logic [1:0]                b_resp_i,
    input  logic                      b_valid_i,
    output logic                      b_ready_o,
    output logic [ADDR_WIDTH-1:0]     ar_addr_o,
    output logic [2:0]                ar_prot_o,
    output logic                      ar_valid_o,
    input  logic                      ar_ready_i,
    input  logic [DATA_WIDTH-1:0]     r_data_i,
    input  logic [1:0]                r_resp_i,
    input  logic                      r_valid_i,
    output logic                      r_ready_o
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic             STRICT   = (STRICT_ORDER != 0) ? 1'b1 : 1'b0;

    // Wrap-around increment; MAX_OUTSTANDING need not fill the pointer range
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) begin
            return PTR_ZERO;
        end else begin
            return p + PTR_ONE;
        end
    endfunction

    // Request-side registers
    logic                       r_aw_valid;
    logic                       r_w_valid;
    logic                       r_ar_valid;
    logic [ADDR_WIDTH-1:0]      r_aw_addr;
    logic [ADDR_WIDTH-1:0]      r_ar_addr;
    logic [DATA_WIDTH-1:0]      r_w_data;
    logic [BE_W-1:0]            r_w_strb;
    logic                       r_last_we;

    // Issue-order FIFO (1 = write) and in-flight count
    logic [MAX_OUTSTANDING-1:0] r_order_fifo;
    logic [PTR_W-1:0]           r_wr_ptr;
    logic [PTR_W-1:0]           r_rd_ptr;
    logic [CNT_W-1:0]           r_count;

    // Core response registers
    logic                       r_rvalid;
    logic                       r_err;
    logic [DATA_WIDTH-1:0]      r_rdata;

    logic w_head_we;
    logic w_nempty;
    logic w_busy;
    logic w_full;
    logic w_type_block;
    logic w_stall;
    logic w_grant;
    logic w_r_ready;
    logic w_b_ready;
    logic w_r_hs;
    logic w_b_hs;
    logic w_pop;
    logic w_unused_resp;

    assign w_head_we    = r_order_fifo[r_rd_ptr];
    assign w_nempty     = (r_count != CNT_ZERO);
    assign w_busy       = r_aw_valid | r_w_valid | r_ar_valid;
    // Registered count only: a response popping this cycle does not free a slot yet
    assign w_full       = (r_count == CNT_MAX);
    // In strict mode a type switch waits until everything in flight has returned
    assign w_type_block = STRICT & w_nempty & (data_we_i != r_last_we);
    // Nothing is granted while reset is held, so no request is silently dropped
    assign w_stall      = rst_i | w_busy | w_full | w_type_block;
    assign w_grant      = data_req_i & ~w_stall;

    // Only the channel matching the oldest outstanding transaction may complete
    assign w_r_ready    = w_nempty & ~w_head_we;
    assign w_b_ready    = w_nempty & w_head_we;
    assign w_r_hs       = r_valid_i & w_r_ready;
    assign w_b_hs       = b_valid_i & w_b_ready;
    assign w_pop        = w_r_hs | w_b_hs;

    // Only resp[1] (SLVERR/DECERR) matters; EXOKAY vs OKAY is irrelevant here
    assign w_unused_resp = b_resp_i[0] ^ r_resp_i[0];

    // Channel valids and payload: loaded on grant, each valid cleared by its own handshake
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_aw_valid <= 1'b0;
            r_w_valid  <= 1'b0;
            r_ar_valid <= 1'b0;
            r_aw_addr  <= {ADDR_WIDTH{1'b0}};
            r_ar_addr  <= {ADDR_WIDTH{1'b0}};
            r_w_data   <= {DATA_WIDTH{1'b0}};
            r_w_strb   <= {BE_W{1'b0}};
            r_last_we  <= 1'b0;
        end else if (w_grant) begin
            // A grant implies all three valids are already low
            r_last_we <= data_we_i;
            if (data_we_i) begin
                r_aw_valid <= 1'b1;
                r_w_valid  <= 1'b1;
                r_aw_addr  <= data_addr_i;
                r_w_data   <= data_wdata_i;
                r_w_strb   <= data_be_i;
            end else begin
                r_ar_valid <= 1'b1;
                r_ar_addr  <= data_addr_i;
            end
        end else begin
            if (r_aw_valid && aw_ready_i) begin
                r_aw_valid <= 1'b0;
            end
            if (r_w_valid && w_ready_i) begin
                r_w_valid <= 1'b0;
            end
            if (r_ar_valid && ar_ready_i) begin
                r_ar_valid <= 1'b0;
            end
        end
    end

    // Issue-order FIFO: push type on grant, pop on the accepted response
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_order_fifo <= {MAX_OUTSTANDING{1'b0}};
            r_wr_ptr     <= PTR_ZERO;
            r_rd_ptr     <= PTR_ZERO;
        end else begin
            if (w_grant) begin
                r_order_fifo[r_wr_ptr] <= data_we_i;
                r_wr_ptr               <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
        end
    end

    // Outstanding count: net of this cycle's grant and pop
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= CNT_ZERO;
        end else begin
            case ({w_grant, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Core response: one-cycle pulse after the popping handshake; rdata holds otherwise
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= {DATA_WIDTH{1'b0}};
        end else begin
            r_rvalid <= w_pop;
            if (w_r_hs) begin
                r_rdata <= r_data_i;
                r_err   <= r_resp_i[1];
            end else if (w_b_hs) begin
                r_rdata <= {DATA_WIDTH{1'b0}};
                r_err   <= b_resp_i[1];
            end else begin
                r_err   <= 1'b0;
            end
        end
    end

    assign data_gnt_o    = w_grant;
    assign data_rvalid_o = r_rvalid;
    assign data_err_o    = r_err;
    assign data_rdata_o  = r_rdata;

    assign aw_addr_o     = r_aw_addr;
    assign aw_prot_o     = 3'b000;
    assign aw_valid_o    = r_aw_valid;
    assign w_data_o      = r_w_data;
    assign w_strb_o      = r_w_strb;
    assign w_valid_o     = r_w_valid;
    assign b_ready_o     = w_b_ready;

    assign ar_addr_o     = r_ar_addr;
    assign ar_prot_o     = 3'b000;
    assign ar_valid_o    = r_ar_valid;
    assign r_ready_o     = w_r_ready;

endmodule

// File: tb/tb_core2axi_lite_ot.sv
// ---------------------------------------------------------------------------
// Testbench for core2axi_lite_ot.
//
// Two instances are built, one with STRICT_ORDER=0 and one with
// STRICT_ORDER=1. Each instance has its own random core master, its own
// AXI4-Lite slave and its own transaction-level reference model.
//
// The reference model tracks:
// - the queue of issued-but-unanswered transactions,
// - the pending address/data channel beats,
// - the type of the last issued transaction.
//
// From this model it predicts the grant, the ready signals, the channel
// valids/payloads and the core response for every cycle.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_core2axi_lite_ot;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BW  = DW / 8;
    localparam int MAX = 4;

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    resp;
        int            due;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;
    bit   hold_slv;
    bit   stop_req;
    bit   fin;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    // Free-running cycle counter used for slave response scheduling
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int inst,
                             input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s [inst %0d] @%0t: got %0h, expected %0h",
                     tag, inst, $time, got, exp);
        end
    endtask

    function automatic int pick_delay();
        if (stop_req) begin
            return $urandom_range(2, 0);
        end else if ($urandom_range(7, 0) == 0) begin
            return $urandom_range(25, 10);
        end else begin
            return $urandom_range(3, 0);
        end
    endfunction

    function automatic logic [1:0] pick_resp();
        return 2'($urandom_range(3, 0));
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam bit STRICT = (g == 1);

        logic          req, gnt, rvalid, err, we;
        logic [AW-1:0] addr;
        logic [BW-1:0] be;
        logic [DW-1:0] wdata, rdata;
        logic [AW-1:0] aw_addr, ar_addr;
        logic [2:0]    aw_prot, ar_prot;
        logic          aw_valid, aw_ready, w_valid, w_ready, ar_valid, ar_ready;
        logic [DW-1:0] w_data, r_data;
        logic [BW-1:0] w_strb;
        logic [1:0]    b_resp, r_resp;
        logic          b_valid, b_ready, r_valid, r_ready;

        core2axi_lite_ot #(
            .ADDR_WIDTH     (AW),
            .DATA_WIDTH     (DW),
            .MAX_OUTSTANDING(MAX),
            .STRICT_ORDER   (g)
        ) u_dut (
            .clk_i        (clk),
            .rst_i        (rst),
            .data_req_i   (req),
            .data_gnt_o   (gnt),
            .data_rvalid_o(rvalid),
            .data_err_o   (err),
            .data_addr_i  (addr),
            .data_we_i    (we),
            .data_be_i    (be),
            .data_wdata_i (wdata),
            .data_rdata_o (rdata),
            .aw_addr_o    (aw_addr),
            .aw_prot_o    (aw_prot),
            .aw_valid_o   (aw_valid),
            .aw_ready_i   (aw_ready),
            .w_data_o     (w_data),
            .w_strb_o     (w_strb),
            .w_valid_o    (w_valid),
            .w_ready_i    (w_ready),
            .b_resp_i     (b_resp),
            .b_valid_i    (b_valid),
            .b_ready_o    (b_ready),
            .ar_addr_o    (ar_addr),
            .ar_prot_o    (ar_prot),
            .ar_valid_o   (ar_valid),
            .ar_ready_i   (ar_ready),
            .r_data_i     (r_data),
            .r_resp_i     (r_resp),
            .r_valid_i    (r_valid),
            .r_ready_o    (r_ready)
        );

        // Reference model state
        bit            inflight[$];   // issue order, 1 = write
        rsp_t          rq[$];         // slave read responses, in AR order
        rsp_t          bq[$];         // slave write responses, in AW/W order
        bit            aw_pend, w_pend, ar_pend, wr_open, last_we;
        bit            exp_pulse, exp_err, gnt_d, r_hs_d, b_hs_d, fin_done;
        logic [AW-1:0] m_aw_addr, m_ar_addr;
        logic [DW-1:0] m_wdata, m_rdata;
        logic [BW-1:0] m_strb;

        // Core master, AXI slave and reference model, one cycle per iteration
        initial begin : drv
            bit exp_gnt, exp_rr, exp_br, hs_aw, hs_w, hs_ar;
            req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
            aw_ready = 1'b0; w_ready = 1'b0; ar_ready = 1'b0;
            b_valid = 1'b0; b_resp = 2'b00; r_valid = 1'b0; r_data = '0; r_resp = 2'b00;
            fin_done = 1'b0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    inflight.delete(); rq.delete(); bq.delete();
                    aw_pend = 1'b0; w_pend = 1'b0; ar_pend = 1'b0; wr_open = 1'b0;
                    last_we = 1'b0; exp_pulse = 1'b0; gnt_d = 1'b0;
                    r_hs_d = 1'b0; b_hs_d = 1'b0; m_rdata = '0;
                    req = 1'b0; r_valid = 1'b0; b_valid = 1'b0;
                    aw_ready = 1'b0; w_ready = 1'b0; ar_ready = 1'b0;
                    check_val("rst_state", g,
                              64'({rvalid, err, aw_valid, w_valid, ar_valid, b_ready, r_ready}), 64'd0);
                    check_val("rst_rdata", g, 64'(rdata), 64'd0);
                end else begin
                    // Registered outputs reflect the previous edge
                    check_val("rvalid", g, 64'(rvalid), 64'(exp_pulse));
                    if (exp_pulse) check_val("err", g, 64'(err), 64'(exp_err));
                    check_val("rdata", g, 64'(rdata), 64'(m_rdata));
                    check_val("aw_valid", g, 64'(aw_valid), 64'(aw_pend));
                    check_val("w_valid", g, 64'(w_valid), 64'(w_pend));
                    check_val("ar_valid", g, 64'(ar_valid), 64'(ar_pend));
                    if (aw_pend) check_val("aw_addr", g, 64'(aw_addr), 64'(m_aw_addr));
                    if (w_pend) check_val("w_data", g, 64'({w_strb, w_data}), 64'({m_strb, m_wdata}));
                    if (ar_pend) check_val("ar_addr", g, 64'(ar_addr), 64'(m_ar_addr));
                    check_val("prot", g, 64'({aw_prot, ar_prot}), 64'd0);
                    exp_pulse = 1'b0;
                    if (fin && !fin_done) begin
                        fin_done = 1'b1;
                        check_val("drain", g, 64'(inflight.size()), 64'd0);
                    end

                    // New inputs for this cycle
                    if (gnt_d) req = 1'b0;
                    if (r_hs_d) r_valid = 1'b0;
                    if (b_hs_d) b_valid = 1'b0;
                    if (!req && !stop_req && ($urandom_range(3, 0) != 0)) begin
                        req   = 1'b1;
                        we    = 1'($urandom_range(1, 0));
                        addr  = $urandom & 32'hFFFF_FFFC;
                        be    = 4'($urandom_range(15, 0));
                        wdata = $urandom;
                    end
                    aw_ready = ($urandom_range(3, 0) != 0);
                    w_ready  = ($urandom_range(3, 0) != 0);
                    ar_ready = ($urandom_range(3, 0) != 0);
                    if (!r_valid && rq.size() != 0 && !hold_slv && cyc >= rq[0].due) begin
                        r_valid = 1'b1; r_data = rq[0].data; r_resp = rq[0].resp;
                    end
                    if (!b_valid && bq.size() != 0 && !hold_slv && cyc >= bq[0].due) begin
                        b_valid = 1'b1; b_resp = bq[0].resp;
                    end
                    #1;

                    // Combinational outputs against the model's prediction
                    exp_gnt = req && !aw_pend && !w_pend && !ar_pend && (inflight.size() < MAX)
                              && !(STRICT && inflight.size() != 0 && we != last_we);
                    exp_rr  = (inflight.size() != 0) ? !inflight[0] : 1'b0;
                    exp_br  = (inflight.size() != 0) ?  inflight[0] : 1'b0;
                    check_val("gnt", g, 64'(gnt), 64'(exp_gnt));
                    check_val("r_ready", g, 64'(r_ready), 64'(exp_rr));
                    check_val("b_ready", g, 64'(b_ready), 64'(exp_br));

                    // Handshakes at the coming edge
                    hs_aw  = aw_pend && aw_ready;
                    hs_w   = w_pend && w_ready;
                    hs_ar  = ar_pend && ar_ready;
                    r_hs_d = r_valid && exp_rr;
                    b_hs_d = b_valid && exp_br;
                    gnt_d  = exp_gnt;

                    if (r_hs_d) begin
                        exp_pulse = 1'b1; exp_err = r_resp[1]; m_rdata = r_data;
                        void'(inflight.pop_front()); void'(rq.pop_front());
                    end else if (b_hs_d) begin
                        exp_pulse = 1'b1; exp_err = b_resp[1]; m_rdata = '0;
                        void'(inflight.pop_front()); void'(bq.pop_front());
                    end
                    if (hs_ar) begin
                        ar_pend = 1'b0;
                        rq.push_back('{data: $urandom, resp: pick_resp(), due: cyc + 1 + pick_delay()});
                    end
                    if (hs_aw) aw_pend = 1'b0;
                    if (hs_w)  w_pend  = 1'b0;
                    if (wr_open && !aw_pend && !w_pend) begin
                        wr_open = 1'b0;
                        bq.push_back('{data: 32'd0, resp: pick_resp(), due: cyc + 1 + pick_delay()});
                    end
                    if (exp_gnt) begin
                        inflight.push_back(we);
                        last_we = we;
                        if (we) begin
                            aw_pend = 1'b1; w_pend = 1'b1; wr_open = 1'b1;
                            m_aw_addr = addr; m_wdata = wdata; m_strb = be;
                        end else begin
                            ar_pend = 1'b1; m_ar_addr = addr;
                        end
                    end
                end
            end
        end

        // Reset must clear every output without waiting for a clock edge
        initial begin : rst_chk
            forever begin
                @(posedge rst);
                #1;
                check_val("async_rst", g,
                          64'({gnt, rvalid, err, aw_valid, w_valid, ar_valid, b_ready, r_ready}), 64'd0);
                check_val("async_rst_rdata", g, 64'(rdata), 64'd0);
            end
        end
    end

    // Phase control: random traffic, mid-flight reset, more traffic, drain
    initial begin
        rst = 1'b1; hold_slv = 1'b0; stop_req = 1'b0; fin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #3; rst = 1'b0;
        repeat (3000) @(posedge clk);
        // Let transactions pile up with no responses, then reset mid-flight
        hold_slv = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk); #3; rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #3; rst = 1'b0; hold_slv = 1'b0;
        repeat (1000) @(posedge clk);
        stop_req = 1'b1;
        repeat (200) @(posedge clk);
        fin = 1'b1;
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
